// File: rtl/data_buffer.sv
// Shared 64x8 FIFO between the USB packet path and the host data path.
// Push/pop strobes from either side act on one storage array; read data is registered per sink.
module data_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int OCC_W  = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              store_rx_packet_data,
    input  logic              store_tx_data,
    input  logic              get_rx_data,
    input  logic              get_tx_packet_data,
    input  logic              flush,
    input  logic              clear,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic [DATA_W-1:0] tx_data,
    output logic [OCC_W-1:0]  buffer_occupancy,
    output logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_packet_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_packet_data_q, tx_packet_data_d;

    logic              empty_of;
    logic              full_of;
    logic              do_clr;
    logic              do_push;
    logic              do_pop;
    logic [DATA_W-1:0] wr_byte;
    logic [DATA_W-1:0] rd_byte;

    always_comb begin
        empty_of = (occ_q == '0);
        full_of  = (occ_q == OCC_W'(DEPTH));
        do_clr   = flush | clear;
        // Full/empty are judged on the current count, so a push into an empty
        // buffer never forwards to a same-cycle pop.
        do_push  = (store_rx_packet_data | store_tx_data) & ~full_of & ~do_clr;
        do_pop   = (get_rx_data | get_tx_packet_data) & ~empty_of & ~do_clr;
        wr_byte  = store_rx_packet_data ? rx_packet_data : tx_data;
        rd_byte  = mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        occ_d            = occ_q;
        rx_data_d        = rx_data_q;
        tx_packet_data_d = tx_packet_data_q;

        if (do_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (get_rx_data) begin
                    rx_data_d = rd_byte;
                end
                if (get_tx_packet_data) begin
                    tx_packet_data_d = rd_byte;
                end
            end
            case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            rx_data_q        <= '0;
            tx_packet_data_q <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            rx_data_q        <= rx_data_d;
            tx_packet_data_q <= tx_packet_data_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push && !n_rst) begin
            mem_q[wr_ptr_q] <= wr_byte;
        end
    end

    assign buffer_occupancy = occ_q;
    assign rx_data          = rx_data_q;
    assign tx_packet_data   = tx_packet_data_q;

endmodule

// File: tb/tb_data_buffer.sv
// Randomized and directed bench for data_buffer with a queue-based reference model
// and a scoreboard monitor that checks every cycle's registered outputs.
module tb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst, srx, stx, grx, gtx, flush, clear;
    logic [7:0] rxd, txd;
    wire  [6:0] occ;
    wire  [7:0] rx_out, tx_out;

    always #5 clk = ~clk;

    data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .store_rx_packet_data (srx),
        .store_tx_data        (stx),
        .get_rx_data          (grx),
        .get_tx_packet_data   (gtx),
        .flush                (flush),
        .clear                (clear),
        .rx_packet_data       (rxd),
        .tx_data              (txd),
        .buffer_occupancy     (occ),
        .rx_data              (rx_out),
        .tx_packet_data       (tx_out)
    );

    typedef struct {
        int         occ;
        logic [7:0] rx;
        logic [7:0] tx;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mq[$];
    logic [7:0] rx_m, tx_m;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain byte queue plus the last byte handed to each sink.
    task automatic step();
        bit         pop_ok, push_ok;
        logic [7:0] v;
        exp_t       e;
        @(posedge clk);
        if (n_rst) begin
            mq.delete();
            rx_m = 8'd0;
            tx_m = 8'd0;
        end else if (flush || clear) begin
            mq.delete();
        end else begin
            pop_ok  = (grx || gtx) && (mq.size() > 0);
            push_ok = (srx || stx) && (mq.size() < 64);
            if (pop_ok) begin
                v = mq.pop_front();
                if (grx) rx_m = v;
                if (gtx) tx_m = v;
            end
            if (push_ok) mq.push_back(srx ? rxd : txd);
        end
        e.occ = mq.size();
        e.rx  = rx_m;
        e.tx  = tx_m;
        expq.push_back(e);
        #1;
    endtask

    task automatic drive(input bit r, input bit sr, input bit st, input bit gr, input bit gt,
                         input bit fl, input bit cl, input logic [7:0] a, input logic [7:0] b);
        n_rst = r; srx = sr; stx = st; grx = gr; gtx = gt; flush = fl; clear = cl;
        rxd = a; txd = b;
        step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("occupancy", 32'(occ), 32'(e.occ));
            chk("rx_data", 32'(rx_out), 32'(e.rx));
            chk("tx_packet_data", 32'(tx_out), 32'(e.tx));
        end
    end

    initial begin
        logic [7:0] seq4 [4];
        logic [7:0] last_byte;
        int         phase;
        seq4[0] = 8'd100; seq4[1] = 8'd29; seq4[2] = 8'd87; seq4[3] = 8'd118;
        last_byte = 8'd0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_occ", 32'(occ), 0);
        chk("reset_rx", 32'(rx_out), 0);
        chk("reset_tx", 32'(tx_out), 0);

        // single RX push and pop
        drive(0, 1, 0, 0, 0, 0, 0, 8'd100, 0);
        chk("t1_occ", 32'(occ), 1);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("t1_rx", 32'(rx_out), 100);
        chk("t1_occ_empty", 32'(occ), 0);

        // four TX bytes in, four out in order
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 0, 0, seq4[i]);
        chk("t2_occ", 32'(occ), 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
            chk("t2_tx_order", 32'(tx_out), 32'(seq4[i]));
        end

        // fill to capacity, then two ignored pushes
        for (int i = 0; i < 66; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 8'($urandom), 0);
            if (i == 63) last_byte = rxd;
        end
        chk("t3_full_occ", 32'(occ), 64);

        // drain with two extra cycles, then two later gets on empty
        for (int i = 0; i < 66; i++) drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t4_last_byte", 32'(tx_out), 32'(last_byte));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t4_hold_tx", 32'(tx_out), 32'(last_byte));
        chk("t4_empty_occ", 32'(occ), 0);

        // flush, then clear, with strobes in the clearing cycle discarded
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 8'(10 + i), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 1, 0, 8'd77, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("t5_flush_occ", 32'(occ), 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 8'(20 + i), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 1, 0, 8'd55);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t5_clear_occ", 32'(occ), 0);
        drive(0, 1, 0, 0, 0, 0, 0, 8'd200, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("t5_new_byte", 32'(rx_out), 200);

        // empty push+pop: push only; then concurrent push/pop at occupancy 3
        drive(0, 1, 0, 1, 1, 0, 0, 8'd1, 0);
        chk("t6_empty_pushpop", 32'(occ), 1);
        drive(0, 1, 0, 0, 0, 0, 0, 8'd2, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 8'd3);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0, 0, 0, 0, 8'(40 + i));
        chk("t6_occ_steady", 32'(occ), 3);
        chk("t6_order", 32'(rx_out), 41);
        drive(0, 1, 0, 0, 0, 0, 0, 8'd9, 0);
        drive(1, 1, 0, 1, 0, 0, 0, 8'd9, 0);
        chk("t6_rst_occ", 32'(occ), 0);
        chk("t6_rst_rx", 32'(rx_out), 0);
        chk("t6_rst_tx", 32'(tx_out), 0);

        // random traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 800; i++) begin
            phase = (i / 120) % 2;
            drive(($urandom_range(0, 299) == 0),
                  (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1,
                  (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 79) == 0),
                  8'($urandom), 8'($urandom));
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
